counter_rr_scheduler: RTL and testbench
=======================================

// Module: counter_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one up/down counter datapath among NREQ requesters.
//  Each requester asks for an increment or decrement. The block grants one request
//  at a time and drives the datapath incr/decr strobes for exactly one cycle.
//  It reads back the registered count and refuses operations that would over/underflow.
//  Sits between requesting control units and the counter datapath unit.
// PARAMETERS
//  NREQ       4    number of requesters (2..8)
//  WIDTH      4    counter width; must match the datapath count width
//  MAX_COUNT  15   upper saturation limit (<= 2**WIDTH-1); lower limit is 0
// PORTS
//  clk      in   1        rising-edge clock
//  reset    in   1        synchronous, active-high reset
//  req      in   NREQ     per-requester request; held high until grant seen
//  dir      in   NREQ     per-requester direction, 1=up, 0=down; stable while req high
//  count    in   WIDTH    registered count fed back from the datapath
//  incr     out  1        datapath increment strobe, one-cycle pulse
//  decr     out  1        datapath decrement strobe, one-cycle pulse
//  grant    out  NREQ     one-hot grant, one-cycle pulse
//  refused  out  1        pulses with grant when the granted op was blocked by a limit
//  busy     out  1        high in S_ISSUE and S_SETTLE
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1): state=S_IDLE, incr=decr=0, grant=0,
//    refused=0, busy=0, RR pointer=0 (requester 0 highest priority).
//  - All outputs are registered. incr and decr are never high together.
//    At most one grant bit is set.
//  - FSM states:
//      S_IDLE: no op in flight. If any req is high, arbitrate and go to S_ISSUE.
//      S_ISSUE: grant/incr/decr/refused visible this cycle. Always go to S_SETTLE.
//      S_SETTLE: count now reflects the op. If any req is high, arbitrate and go
//        to S_ISSUE; otherwise go to S_IDLE.
//  - Arbitration: the winner is the first req bit searching upward from
//    (last granted index + 1), mod NREQ. The pointer updates only on grant.
//  - Throughput: at most 1 op per 2 cycles. Latency from req seen in S_IDLE to
//    grant/strobe is 1 cycle.
//  - Limit check, evaluated on the current count at the arbitration edge:
//    up with count==MAX_COUNT -> refused=1, incr=0.
//    down with count==0 -> refused=1, decr=0. Grant pulses regardless.
//  - Requester must drop req, or change it for a new op, in the cycle after its grant.
//    A req still high in S_SETTLE is treated as a new request.
//  - Deasserting req before grant withdraws it; no grant is issued to it.
//  - Reset in any state aborts the op: the next cycle is S_IDLE with all outputs 0.
//    The datapath shares reset, so count=0.
//  - Width rule: comparisons are WIDTH-bit unsigned. MAX_COUNT is truncated to WIDTH.
// CONFIGURATION
//  CNT_SCHED_WRAP_EN defined: limit check disabled.
//    refused is tied 0, and every grant produces incr (dir=1) or decr (dir=0).
//    The datapath wraps modulo 2**WIDTH: 15+1 -> 0, 0-1 -> 15.
//  Not defined (default): saturating behaviour as above.
// TESTING
//  1. Reset, req[0]=1, dir[0]=1 for one cycle:
//     grant=0001 and incr=1 one cycle later; count=1 after that; busy high 2 cycles.
//  2. req=1111 held continuously, dir=1111:
//     grants 0001,0010,0100,1000,0001 every 2 cycles; count goes 0->4 after 4 grants.
//  3. Drive count to 15, req[2]=1, dir[2]=1:
//     grant=0100, refused=1, incr=0; count stays 15.
//     With CNT_SCHED_WRAP_EN: incr=1, refused=0, count=0.
//  4. count=0, req[1]=1, dir[1]=0:
//     refused=1, decr=0, count stays 0.
//     With CNT_SCHED_WRAP_EN: decr=1, count=15.
//  5. Assert reset during S_ISSUE:
//     next cycle grant=0, incr=decr=0, busy=0, pointer=0.
//     Then req=0110 -> grant=0010 first.
//  6. req[3] raised then dropped before arbitration, req[1] steady:
//     only grant=0010 is issued; no grant=1000 appears.

Source files
------------

// File: rtl/counter_rr_scheduler.sv
// ----------------------------------------------------------------------------
// counter_rr_scheduler
//
// Round-robin scheduler that shares one up/down counter datapath among NREQ
// requesters. One request is granted at a time; the granted operation is
// driven onto the datapath as a single-cycle incr or decr strobe. Operations
// that would push the counter past MAX_COUNT or below zero are refused: the
// grant still pulses, together with refused, and no strobe is issued.
//
// Build option:
//   CNT_SCHED_WRAP_EN  When defined, the limit check is removed. refused stays
//                      0 and every grant produces a strobe; the datapath is
//                      expected to wrap modulo 2**WIDTH.
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   WIDTH      counter width, must match the datapath count width
//   MAX_COUNT  upper saturation limit, truncated to WIDTH bits; lower limit 0
//
// Ports:
//   clk_i      rising-edge clock
//   reset_i    synchronous, active-high reset
//   req_i      per-requester request, held until its grant is seen
//   dir_i      per-requester direction (1 = up, 0 = down), stable while req high
//   count_i    registered count fed back from the datapath
//   incr_o     datapath increment strobe, one-cycle pulse
//   decr_o     datapath decrement strobe, one-cycle pulse
//   grant_o    one-hot grant, one-cycle pulse
//   refused_o  pulses with grant when the granted op hit a limit
//   busy_o     high while an operation is issuing or settling
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module counter_rr_scheduler #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  dir_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             incr_o,
    output logic             decr_o,
    output logic [NREQ-1:0]  grant_o,
    output logic             refused_o,
    output logic             busy_o
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StSettle
    } state_e;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;       // highest-priority requester index
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              incr_q, incr_d;
    logic              decr_q, decr_d;
    logic              refused_q, refused_d;
    logic              busy_q, busy_d;

    // ------------------------------------------------------------------------
    // Round-robin search: first requester at or above ptr_q, wrapping mod NREQ
    // ------------------------------------------------------------------------
    logic              win_found;
    logic [PtrW-1:0]   win_idx;
    logic [PtrW-1:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PtrW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Limit check on the count present at the arbitration edge
    // ------------------------------------------------------------------------
    logic win_dir;
    logic blocked;

    assign win_dir = dir_i[win_idx];

`ifdef CNT_SCHED_WRAP_EN
    // Datapath wraps, so every op is allowed; count_i is not consulted.
    assign blocked = 1'b0;
    logic unused_count;
    assign unused_count = ^count_i;
`else
    assign blocked = win_dir ? (count_i == MaxCnt) : (count_i == '0);
`endif

    // Pointer moves to the slot after the winner so the winner becomes lowest.
    logic [PtrW-1:0] ptr_after_win;
    assign ptr_after_win = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = '0;
        incr_d    = 1'b0;
        decr_d    = 1'b0;
        refused_d = 1'b0;
        busy_d    = 1'b0;

        unique case (state_q)
            // Idle and settle both arbitrate: settle is the earliest point at
            // which the count reflects the previous op.
            StIdle, StSettle: begin
                if (win_found) begin
                    state_d   = StIssue;
                    ptr_d     = ptr_after_win;
                    grant_d   = NREQ'(1) << win_idx;
                    incr_d    = win_dir & ~blocked;
                    decr_d    = ~win_dir & ~blocked;
                    refused_d = blocked;
                    busy_d    = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                state_d = StSettle;
                busy_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers (synchronous reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            grant_q   <= '0;
            incr_q    <= 1'b0;
            decr_q    <= 1'b0;
            refused_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            incr_q    <= incr_d;
            decr_q    <= decr_d;
            refused_q <= refused_d;
            busy_q    <= busy_d;
        end
    end

    assign grant_o   = grant_q;
    assign incr_o    = incr_q;
    assign decr_o    = decr_q;
    assign refused_o = refused_q;
    assign busy_o    = busy_q;

    // ------------------------------------------------------------------------
    // Output invariants
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(incr_q && decr_q))
                else $error("incr and decr high together");
            assert ($onehot0(grant_q))
                else $error("grant not one-hot");
            assert (!(incr_q || decr_q || refused_q) || (grant_q != '0))
                else $error("strobe without grant");
        end
    end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// ----------------------------------------------------------------------------
// Bench for counter_rr_scheduler. A small counter datapath lives here so that
// count feeds back into the scheduler. Expected outputs come from a
// cycle-level reference model of the scheduling rules.
// ----------------------------------------------------------------------------
module tb_counter_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int MAXC  = 15;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  dir = '0;
    logic [WIDTH-1:0] count;
    logic             incr, decr, refused, busy;
    logic [NREQ-1:0]  grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    counter_rr_scheduler #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .req_i     (req),
        .dir_i     (dir),
        .count_i   (count),
        .incr_o    (incr),
        .decr_o    (decr),
        .grant_o   (grant),
        .refused_o (refused),
        .busy_o    (busy)
    );

    // Datapath: registered up/down counter sharing the reset.
    always_ff @(posedge clk) begin
        if (rst)       count <= '0;
        else if (incr) count <= count + 1'b1;
        else if (decr) count <= count - 1'b1;
    end

    // Reference model state
    int              m_phase = 0;   // 0 nothing in flight, 1 op issued, 2 settling
    int              m_ptr   = 0;   // requester searched first
    int              m_cnt   = 0;
    logic [NREQ-1:0] e_grant = '0;
    logic            e_incr  = 1'b0;
    logic            e_decr  = 1'b0;
    logic            e_ref   = 1'b0;
    logic            e_busy  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Predict the effect of the next clock edge, apply inputs, then compare.
    task automatic cycle(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dr);
        int  w;
        int  cnt_now;
        bit  lim;
        rst = r;
        req = rq;
        dir = dr;
        if (r) begin
            m_phase = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            e_grant = '0;
            e_incr  = 1'b0;
            e_decr  = 1'b0;
            e_ref   = 1'b0;
            e_busy  = 1'b0;
        end else begin
            cnt_now = m_cnt;
            // strobes currently visible land in the datapath at this edge
            if (e_incr)      m_cnt = (m_cnt + 1) % MODV;
            else if (e_decr) m_cnt = (m_cnt + MODV - 1) % MODV;
            e_grant = '0;
            e_incr  = 1'b0;
            e_decr  = 1'b0;
            e_ref   = 1'b0;
            if (m_phase == 1) begin
                m_phase = 2;
                e_busy  = 1'b1;
            end else if (rq != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && rq[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
`ifdef CNT_SCHED_WRAP_EN
                lim = 1'b0;
`else
                lim = dr[w] ? (cnt_now == MAXC) : (cnt_now == 0);
`endif
                e_grant[w] = 1'b1;
                e_incr  = dr[w] && !lim;
                e_decr  = !dr[w] && !lim;
                e_ref   = lim;
                e_busy  = 1'b1;
                m_ptr   = (w + 1) % NREQ;
                m_phase = 1;
            end else begin
                m_phase = 0;
                e_busy  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("grant",   32'(grant),   32'(e_grant));
        check_eq("incr",    32'(incr),    32'(e_incr));
        check_eq("decr",    32'(decr),    32'(e_decr));
        check_eq("refused", 32'(refused), 32'(e_ref));
        check_eq("busy",    32'(busy),    32'(e_busy));
        check_eq("count",   32'(count),   32'(m_cnt));
    endtask

    initial begin : main
        logic [NREQ-1:0] rq;
        logic [NREQ-1:0] dr;
        int              up_pct;

        // Reset state
        cycle(1'b1, '0, '0);
        cycle(1'b1, '0, '0);
        cycle(1'b0, '0, '0);

        // Single up request held for one cycle
        cycle(1'b0, 4'b0001, 4'b0001);
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);

        // All requesters counting up continuously: rotation, then saturation
        for (int i = 0; i < 40; i++) cycle(1'b0, 4'b1111, 4'b1111);
        // One more up at the top limit from requester 2 alone
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0100, 4'b0100);
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);

        // All requesters counting down: reaches 0, then refusals
        for (int i = 0; i < 40; i++) cycle(1'b0, 4'b1111, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0010, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);

        // Reset while an op is issuing, then check pointer restart
        cycle(1'b0, 4'b1000, 4'b1000);
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0110, 4'b0110);
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);

        // Withdrawn request: req[3] only visible during issue, req[1] steady
        cycle(1'b0, 4'b0001, 4'b0001);
        cycle(1'b0, 4'b1010, 4'b1010);
        cycle(1'b0, 4'b0010, 4'b0010);
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);

        // Randomized traffic obeying the request protocol
        rq = '0;
        dr = '0;
        for (int c = 0; c < 1600; c++) begin
            up_pct = ((c / 200) % 2 == 0) ? 85 : 15;
            for (int i = 0; i < NREQ; i++) begin
                if (e_grant[i]) begin
                    if ($urandom_range(1, 0) == 1) rq[i] = 1'b0;
                    else dr[i] = ($urandom_range(99, 0) < up_pct);
                end else if (rq[i]) begin
                    if ($urandom_range(7, 0) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    rq[i] = 1'b1;
                    dr[i] = ($urandom_range(99, 0) < up_pct);
                end
            end
            cycle(($urandom_range(63, 0) == 0), rq, dr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
